// File: rtl/booth_mult_pkg.sv
// Shared FSM encodings, default sizing and the packed operand-tuple width
// for the booth multiplier issue/capture wrapper.
package booth_mult_pkg;

    localparam int WIDTH_DEF   = 8;
    localparam int DEPTH_DEF   = 4;
    localparam int TAG_W_DEF   = 4;
    localparam int TIMEOUT_DEF = 15;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    // Tuple layout, LSB first: mcand, mplier, sign_mode, tag.
    function automatic int tuple_w(input int width, input int tag_w);
        return 2 * width + 2 + tag_w;
    endfunction

endpackage

// File: rtl/booth_op_fifo.sv
// Synchronous FIFO of packed operand tuples; head is visible combinationally, pop takes effect at the edge.
// Push is ignored when full and pop when empty, so callers may drive them unqualified.
module booth_op_fifo
    import booth_mult_pkg::*;
#(
    parameter int W     = tuple_w(WIDTH_DEF, TAG_W_DEF),
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push;
    logic         do_pop;

    // Extra pointer MSB distinguishes a full ring from an empty one.
    always_comb begin
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty    = (wr_ptr_q == rd_ptr_q);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    assign head = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/booth_mult8_issue_ctrl.sv
// Queues operand tuples, issues them one at a time to the booth core with a start pulse, registers tagged products.
// One op per 10 cycles; s_ready = !full, result held until m_ready, watchdog drops ops the core never completes.
module booth_mult8_issue_ctrl
    import booth_mult_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int TAG_W       = TAG_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WIDTH-1:0]     s_mcand,
    input  logic [WIDTH-1:0]     s_mplier,
    input  logic [1:0]           s_sign_mode,
    input  logic [TAG_W-1:0]     s_tag,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [2*WIDTH-1:0]   m_product,
    output logic [TAG_W-1:0]     m_tag,
    output logic                 core_start,
    output logic [WIDTH-1:0]     core_multiplicand,
    output logic [WIDTH-1:0]     core_multiplier,
    output logic [1:0]           core_sign_mode,
    input  logic [2*WIDTH-1:0]   core_product,
    input  logic                 core_done,
    output logic                 busy,
    output logic                 err_timeout
);

    localparam int TW = tuple_w(WIDTH, TAG_W);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0]      push_dat;
    logic [TW-1:0]      head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic [WIDTH-1:0]   head_mcand;
    logic [WIDTH-1:0]   head_mplier;
    logic [1:0]         head_sm;
    logic [TAG_W-1:0]   head_tag;

    logic [1:0]         state_q, state_d;
    logic               core_start_q, core_start_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [1:0]         sign_mode_q, sign_mode_d;
    logic [TAG_W-1:0]   issue_tag_q, issue_tag_d;
    logic [CW-1:0]      wdog_q, wdog_d;
    logic               err_timeout_q, err_timeout_d;
    logic               m_valid_q, m_valid_d;
    logic [2*WIDTH-1:0] m_product_q, m_product_d;
    logic [TAG_W-1:0]   m_tag_q, m_tag_d;
    logic               slot_free;

    assign push_dat = {s_tag, s_sign_mode, s_mplier, s_mcand};
    assign {head_tag, head_sm, head_mplier, head_mcand} = head;

    booth_op_fifo #(
        .W     (TW),
        .DEPTH (DEPTH)
    ) u_op_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (s_valid),
        .push_dat (push_dat),
        .pop      (fifo_pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // The core holds its product from done until the next start, so a
    // parked S_DRAIN can capture it late as long as nothing is issued.
    always_comb begin
        state_d       = state_q;
        core_start_d  = 1'b0;
        mcand_d       = mcand_q;
        mplier_d      = mplier_q;
        sign_mode_d   = sign_mode_q;
        issue_tag_d   = issue_tag_q;
        wdog_d        = wdog_q;
        err_timeout_d = err_timeout_q;
        m_valid_d     = m_valid_q && !m_ready;
        m_product_d   = m_product_q;
        m_tag_d       = m_tag_q;
        fifo_pop      = 1'b0;
        slot_free     = !m_valid_q || m_ready;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    mcand_d      = head_mcand;
                    mplier_d     = head_mplier;
                    sign_mode_d  = head_sm;
                    issue_tag_d  = head_tag;
                    core_start_d = 1'b1;
                    wdog_d       = '0;
                    state_d      = S_RUN;
                end
            end
            S_RUN: begin
                wdog_d = wdog_q + 1'b1;
                if (core_done) begin
                    if (slot_free) begin
                        m_valid_d   = 1'b1;
                        m_product_d = core_product;
                        m_tag_d     = issue_tag_q;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (wdog_q == CW'(TIMEOUT_CYC - 1)) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (slot_free) begin
                    m_valid_d   = 1'b1;
                    m_product_d = core_product;
                    m_tag_d     = issue_tag_q;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            core_start_q  <= 1'b0;
            mcand_q       <= '0;
            mplier_q      <= '0;
            sign_mode_q   <= '0;
            issue_tag_q   <= '0;
            wdog_q        <= '0;
            err_timeout_q <= 1'b0;
            m_valid_q     <= 1'b0;
            m_product_q   <= '0;
            m_tag_q       <= '0;
        end else begin
            state_q       <= state_d;
            core_start_q  <= core_start_d;
            mcand_q       <= mcand_d;
            mplier_q      <= mplier_d;
            sign_mode_q   <= sign_mode_d;
            issue_tag_q   <= issue_tag_d;
            wdog_q        <= wdog_d;
            err_timeout_q <= err_timeout_d;
            m_valid_q     <= m_valid_d;
            m_product_q   <= m_product_d;
            m_tag_q       <= m_tag_d;
        end
    end

    assign s_ready           = !fifo_full;
    assign busy              = (state_q != S_IDLE) || !fifo_empty;
    assign core_start        = core_start_q;
    assign core_multiplicand = mcand_q;
    assign core_multiplier   = mplier_q;
    assign core_sign_mode    = sign_mode_q;
    assign err_timeout       = err_timeout_q;
    assign m_valid           = m_valid_q;
    assign m_product         = m_product_q;
    assign m_tag             = m_tag_q;

endmodule

// File: tb/tb_booth_mult8_issue_ctrl.sv
// Bench for booth_mult8_issue_ctrl: behavioural core stand-in, in-order result scoreboard,
// FIFO occupancy model and directed plus randomized traffic.
module tb_booth_mult8_issue_ctrl;

    localparam int WIDTH       = 8;
    localparam int DEPTH       = 4;
    localparam int TAG_W       = 4;
    localparam int TIMEOUT_CYC = 15;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_mcand = '0;
    logic [7:0]  s_mplier = '0;
    logic [1:0]  s_sign_mode = '0;
    logic [3:0]  s_tag = '0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [15:0] m_product;
    logic [3:0]  m_tag;
    logic        core_start;
    logic [7:0]  core_multiplicand;
    logic [7:0]  core_multiplier;
    logic [1:0]  core_sign_mode;
    logic [15:0] core_product;
    logic        core_done;
    logic        busy;
    logic        err_timeout;

    always #5 clk = ~clk;

    booth_mult8_issue_ctrl #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_mcand(s_mcand), .s_mplier(s_mplier),
        .s_sign_mode(s_sign_mode), .s_tag(s_tag),
        .m_valid(m_valid), .m_ready(m_ready), .m_product(m_product), .m_tag(m_tag),
        .core_start(core_start), .core_multiplicand(core_multiplicand),
        .core_multiplier(core_multiplier), .core_sign_mode(core_sign_mode),
        .core_product(core_product), .core_done(core_done),
        .busy(busy), .err_timeout(err_timeout)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                            input logic [1:0] sm);
        int sa;
        int sb;
        sa = int'(a);
        sb = int'(b);
        if (sm[1] && a[7]) sa = sa - 256;
        if (sm[0] && b[7]) sb = sb - 256;
        return 16'(sa * sb);
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Core stand-in: done is seen by the controller 8 cycles after core_start rises.
    int          kill_budget = 0;
    int          kills_done  = 0;
    int          core_cnt    = 0;
    bit          core_dead   = 1'b0;
    logic [15:0] core_pend   = '0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_cnt  = 0;
            core_done    <= 1'b0;
            core_product <= '0;
        end else begin
            core_done <= 1'b0;
            if (core_start) begin
                core_pend = ref_mul(core_multiplicand, core_multiplier, core_sign_mode);
                core_cnt  = 7;
                core_dead = (kills_done < kill_budget);
                if (core_dead) kills_done++;
            end else if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0 && !core_dead) begin
                    core_done    <= 1'b1;
                    core_product <= core_pend;
                end
            end
        end
    end

    bit ready_cmd = 1'b1;
    bit rnd_ready = 1'b0;
    always @(posedge clk) begin
        #1;
        m_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_cmd;
    end

    typedef struct { logic [15:0] prod; logic [3:0] tag; bit drop; } exp_t;
    typedef struct { logic [7:0] a; logic [7:0] b; logic [1:0] sm; } op_t;

    exp_t        exp_q[$];
    op_t         iss_q[$];
    int          start_cyc[$];
    int          occ = 0;
    int          n_starts = 0;
    int          n_mv = 0;
    bit          push_drop = 1'b0;
    bit          inflight = 1'b0;
    op_t         cur;
    bit          prev_start = 1'b0;
    bit          prev_mv = 1'b0;
    bit          prev_rdy = 1'b0;
    logic [15:0] prev_prod = '0;
    logic [3:0]  prev_tag = '0;

    // Single compare process: issue order/operands, FIFO space, and result stream.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            iss_q.delete();
            occ = 0;
            inflight = 1'b0;
            prev_start = 1'b0;
            prev_mv = 1'b0;
        end else begin
            if (core_start) begin
                n_starts++;
                start_cyc.push_back(cyc);
                chk("start_single_cycle", 32'(prev_start), 32'd0);
                chk("start_has_op", 32'(iss_q.size() > 0), 32'd1);
                if (iss_q.size() > 0) begin
                    cur = iss_q.pop_front();
                    occ--;
                    inflight = 1'b1;
                    chk("issue_mcand", 32'(core_multiplicand), 32'(cur.a));
                    chk("issue_mplier", 32'(core_multiplier), 32'(cur.b));
                    chk("issue_sign", 32'(core_sign_mode), 32'(cur.sm));
                end
            end else if (inflight) begin
                chk("hold_mcand", 32'(core_multiplicand), 32'(cur.a));
                chk("hold_mplier", 32'(core_multiplier), 32'(cur.b));
            end
            chk("s_ready", 32'(s_ready), 32'(occ < DEPTH));
            if (s_valid && s_ready) begin
                iss_q.push_back('{a: s_mcand, b: s_mplier, sm: s_sign_mode});
                exp_q.push_back('{prod: ref_mul(s_mcand, s_mplier, s_sign_mode),
                                  tag: s_tag, drop: push_drop});
                occ++;
            end
            if (m_valid) begin
                n_mv++;
                while (exp_q.size() > 0 && exp_q[0].drop) exp_q.delete(0);
                chk("result_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    chk("m_product", 32'(m_product), 32'(exp_q[0].prod));
                    chk("m_tag", 32'(m_tag), 32'(exp_q[0].tag));
                    if (m_ready) exp_q.delete(0);
                end
                if (prev_mv && !prev_rdy) begin
                    chk("held_product", 32'(m_product), 32'(prev_prod));
                    chk("held_tag", 32'(m_tag), 32'(prev_tag));
                end
            end
            prev_start = core_start;
            prev_mv    = m_valid;
            prev_rdy   = m_ready;
            prev_prod  = m_product;
            prev_tag   = m_tag;
        end
    end

    function automatic int pending_results();
        int n = 0;
        foreach (exp_q[i]) if (!exp_q[i].drop) n++;
        return n;
    endfunction

    task automatic push_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] sm,
                           input logic [3:0] tg, input bit drop, output int pcyc);
        bit hs = 1'b0;
        s_valid = 1'b1;
        s_mcand = a;
        s_mplier = b;
        s_sign_mode = sm;
        s_tag = tg;
        push_drop = drop;
        for (int i = 0; i < 400 && !hs; i++) begin
            @(negedge clk);
            hs = s_ready;
            @(posedge clk);
            #1;
        end
        chk("push_accepted", 32'(hs), 32'd1);
        s_valid = 1'b0;
        push_drop = 1'b0;
        pcyc = cyc;
    endtask

    task automatic wait_idle(input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            ok = !busy && !m_valid && (pending_results() == 0);
        end
        chk("reached_idle", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_single(input logic [7:0] a, input logic [7:0] b, input logic [1:0] sm,
                              input logic [3:0] tg, input logic [15:0] exp_prod);
        int pc;
        bit seen = 1'b0;
        push_op(a, b, sm, tg, 1'b0, pc);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = m_valid;
        end
        chk("single_m_valid", 32'(seen), 32'd1);
        if (seen) begin
            chk_range("single_latency", cyc - pc, 9, 11);
            chk("single_product", 32'(m_product), 32'(exp_prod));
            chk("single_tag", 32'(m_tag), 32'(tg));
        end
        wait_idle(60);
    endtask

    initial begin
        int pc;
        int s0;
        int mv0;
        int a_start;
        bit seen;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_product", 32'(m_product), 32'd0);
        chk("rst_core_start", 32'(core_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Pin the model with hand-computed products
        chk("ref_fd_x_05", 32'(ref_mul(8'hFD, 8'h05, 2'b11)), 32'h0000FFF1);
        chk("ref_80_x_80", 32'(ref_mul(8'h80, 8'h80, 2'b11)), 32'h00004000);

        run_single(8'hFD, 8'h05, 2'b11, 4'd3, 16'hFFF1);
        run_single(8'hFF, 8'hFF, 2'b00, 4'd4, 16'hFE01);
        run_single(8'h80, 8'h80, 2'b11, 4'd5, 16'h4000);

        // Burst of five back-to-back pushes
        s0 = n_starts;
        for (int i = 0; i < 5; i++) begin
            push_op(8'($urandom), 8'($urandom), 2'($urandom), 4'(8 + i), 1'b0, pc);
        end
        chk("burst_fifo_full", 32'(s_ready), 32'd0);
        chk("burst_busy", 32'(busy), 32'd1);
        wait_idle(200);
        chk("burst_starts", 32'(n_starts - s0), 32'd5);

        // Backpressure: output slot blocked for 30 cycles
        ready_cmd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        s0 = n_starts;
        for (int i = 0; i < 3; i++) begin
            push_op(8'($urandom), 8'($urandom), 2'($urandom), 4'(1 + i), 1'b0, pc);
        end
        repeat (30) @(posedge clk);
        #1;
        chk("bp_starts_parked", 32'(n_starts - s0), 32'd2);
        chk("bp_m_valid", 32'(m_valid), 32'd1);
        chk("bp_m_tag", 32'(m_tag), 32'd1);
        chk("bp_busy", 32'(busy), 32'd1);
        ready_cmd = 1'b1;
        wait_idle(200);
        chk("bp_starts_total", 32'(n_starts - s0), 32'd3);

        // Reset in the middle of an operation
        push_op(8'h33, 8'h44, 2'b00, 4'd9, 1'b0, pc);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = core_start;
        end
        chk("midop_started", 32'(seen), 32'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_core_start", 32'(core_start), 32'd0);
        chk("midrst_mcand", 32'(core_multiplicand), 32'd0);
        chk("midrst_mplier", 32'(core_multiplier), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        chk("midrst_m_tag", 32'(m_tag), 32'd0);
        chk("midrst_s_ready", 32'(s_ready), 32'd1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_single(8'h07, 8'h06, 2'b00, 4'd7, 16'h002A);

        // Randomized traffic with random output backpressure
        rnd_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            push_op(8'($urandom), 8'($urandom), 2'($urandom), 4'(i), 1'b0, pc);
            repeat ($urandom_range(0, 12)) @(posedge clk);
            #1;
        end
        wait_idle(2000);
        rnd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Watchdog: the core never answers the first op
        kill_budget = kills_done + 1;
        s0  = n_starts;
        mv0 = n_mv;
        push_op(8'h12, 8'h34, 2'b00, 4'hA, 1'b1, pc);
        push_op(8'hF0, 8'h03, 2'b10, 4'hB, 1'b0, pc);
        chk("wd_err_not_yet", 32'(err_timeout), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = err_timeout;
        end
        chk("wd_err_raised", 32'(seen), 32'd1);
        if (seen && start_cyc.size() > s0) begin
            a_start = start_cyc[s0];
            chk("wd_latency", 32'(cyc - a_start), 32'(TIMEOUT_CYC));
        end
        chk("wd_no_result", 32'(n_mv - mv0), 32'd0);
        wait_idle(100);
        chk("wd_next_issued", 32'(n_starts - s0), 32'd2);
        chk("wd_err_sticky", 32'(err_timeout), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
